// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osc_pkg
//  Description : Shared waveform codes and noise LFSR constants for the DDS
//                oscillator.
//  Revision    : 1.0 - initial release
// ============================================================================
package osc_pkg;

   // Waveform selector codes as presented by the voice register file
   typedef enum logic [1:0] {
      WAVE_SAW   = 2'd0,
      WAVE_PULSE = 2'd1,
      WAVE_TRI   = 2'd2,
      WAVE_NOISE = 2'd3
   } wave_t;

   // Fibonacci LFSR geometry: taps 23 and 18 (1-based), seeded with 1
   localparam int                    LFSR_WIDTH = 23;
   localparam int                    LFSR_TAP   = 18;
   localparam logic [LFSR_WIDTH-1:0] LFSR_SEED  = 23'd1;

endpackage : osc_pkg
`default_nettype wire

// File: rtl/osc_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : osc_lfsr
//  Description : 23-bit Fibonacci LFSR noise source, taps 23/18, advanced one
//                step per asserted step enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_lfsr
   import osc_pkg::*;
(
   input  logic                  sample_clock,
   input  logic                  rst_n,
   input  logic                  step,
   output logic [LFSR_WIDTH-1:0] state
);

   logic [LFSR_WIDTH-1:0] r_state;
   logic                  w_feedback;

   // Plain XOR feedback; the all-zero lock-up state is unreachable from seed 1
   assign w_feedback = r_state[LFSR_WIDTH-1] ^ r_state[LFSR_TAP-1];

   // Shift toward the MSB, inserting the feedback bit at the bottom
   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= LFSR_SEED;
      end else if (step) begin
         r_state <= {r_state[LFSR_WIDTH-2:0], w_feedback};
      end
   end

   assign state = r_state;

endmodule : osc_lfsr
`default_nettype wire

// File: rtl/dds_oscillator.sv
`default_nettype none
// ============================================================================
//  Module      : dds_oscillator
//  Description : Single-voice DDS oscillator. Stage 1 is the phase
//                accumulator with hard sync and carry-out wrap pulse; stage 2
//                is a registered saw/pulse/triangle/noise shaper.
//                Build option DDS_NOISE_EN adds the LFSR noise source; without
//                it the noise selection outputs midscale.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_oscillator
   import osc_pkg::*;
#(
   parameter int BITDEPTH    = 12,
   parameter int BITFRACTION = 12,
   parameter int INC_WIDTH   = 19
) (
   input  logic                 sample_clock,
   input  logic                 rst_n,
   input  logic                 sample_en,
   input  logic [INC_WIDTH-1:0] increment,
   input  logic [1:0]           waveform,
   input  logic [BITDEPTH-1:0]  pulse_width,
   input  logic                 sync_in,
   output logic                 wrap,
   output logic [BITDEPTH-1:0]  out,
   output logic                 out_valid
);

   localparam int                ACC_WIDTH  = BITDEPTH + BITFRACTION;
   localparam logic [BITDEPTH-1:0] c_max      = {BITDEPTH{1'b1}};
   localparam logic [BITDEPTH-1:0] c_zero     = {BITDEPTH{1'b0}};
   localparam logic [BITDEPTH-1:0] c_midscale = {1'b1, {(BITDEPTH-1){1'b0}}};

   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_pending;
   logic                 r_wrap;
   logic [BITDEPTH-1:0]  r_out;
   logic                 r_out_valid;

   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_step;
   logic [BITDEPTH-1:0]  w_phase;
   logic [BITDEPTH-1:0]  w_tri_p2;
   logic [BITDEPTH-1:0]  w_noise;
   logic [BITDEPTH-1:0]  w_shaped;

   // One extra bit on the sum captures the carry-out that drives wrap
   assign w_sum   = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - INC_WIDTH){1'b0}}, increment};
   // A carry only counts when the accumulator actually advances; sync suppresses it
   assign w_step  = sample_en & ~sync_in & w_sum[ACC_WIDTH];
   assign w_phase = r_acc[ACC_WIDTH-1 -: BITDEPTH];
   assign w_tri_p2 = {w_phase[BITDEPTH-2:0], 1'b0};

`ifdef DDS_NOISE_EN
   logic [LFSR_WIDTH-1:0] w_lfsr;

   osc_lfsr u_lfsr (
      .sample_clock (sample_clock),
      .rst_n        (rst_n),
      .step         (w_step),
      .state        (w_lfsr)
   );

   assign w_noise = w_lfsr[LFSR_WIDTH-1 -: BITDEPTH];
`else
   assign w_noise = c_midscale;
`endif

   // Stage 1: phase accumulator, sync clear and carry-out wrap pulse
   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_wrap    <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_pending <= sample_en;
         r_wrap    <= w_step;
         if (sample_en) begin
            if (sync_in) begin
               r_acc <= '0;
            end else begin
               r_acc <= w_sum[ACC_WIDTH-1:0];
            end
         end
      end
   end

   // Waveform shaper working on the freshly updated phase
   always_comb begin
      w_shaped = w_phase;
      case (wave_t'(waveform))
         WAVE_SAW:   w_shaped = w_phase;
         WAVE_PULSE: w_shaped = (w_phase < pulse_width) ? c_max : c_zero;
         WAVE_TRI:   w_shaped = w_phase[BITDEPTH-1] ? ~w_tri_p2 : w_tri_p2;
         WAVE_NOISE: w_shaped = w_noise;
         default:    w_shaped = w_phase;
      endcase
   end

   // Stage 2: register the shaped sample one cycle after each accumulator update
   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_pending;
         if (r_pending) begin
            r_out <= w_shaped;
         end
      end
   end

   assign wrap      = r_wrap;
   assign out       = r_out;
   assign out_valid = r_out_valid;

endmodule : dds_oscillator
`default_nettype wire
